// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
// Module      : life_pkg
// Description : Shared cell constants, FSM state encoding, B3/S23 rule and
//               popcount helper for the Game of Life engine.
// Revision    : 1.0 - initial release
// ============================================================================
package life_pkg;

    localparam logic ALIVE = 1'b1;
    localparam logic DEAD  = 1'b0;

    // FSM state encoding shared by the engine
    typedef logic [1:0] life_state_t;
    localparam life_state_t ST_IDLE    = 2'd0;
    localparam life_state_t ST_COMPUTE = 2'd1;
    localparam life_state_t ST_COMMIT  = 2'd2;

    // Widest board the popcount helper can size (32x32)
    localparam int POP_MAX_BITS = 1024;

    function automatic logic life_rule(input logic alive, input logic [3:0] n);
        if (alive == ALIVE)
            return (n == 4'd2 || n == 4'd3) ? ALIVE : DEAD;
        return (n == 4'd3) ? ALIVE : DEAD;
    endfunction

    function automatic int unsigned popcount(input logic [POP_MAX_BITS-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POP_MAX_BITS; i++)
            if (v[i]) c++;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/life_if.sv
`default_nettype none
// ============================================================================
// Module      : life_if
// Description : Control, read-port and status bundle of the Life engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface life_if #(
    parameter int COLS_LOG2 = 3,
    parameter int ROWS_LOG2 = 3
);
    logic                           step_i;
    logic                           run_i;
    logic                           frame_tick_i;
    logic                           load_i;
    logic [COLS_LOG2+ROWS_LOG2-1:0] rd_addr_i;
    logic                           rd_cell_o;
    logic                           busy_o;
    logic [15:0]                    gen_o;
    logic [COLS_LOG2+ROWS_LOG2:0]   alive_cnt_o;

    modport master (
        output step_i, run_i, frame_tick_i, load_i, rd_addr_i,
        input  rd_cell_o, busy_o, gen_o, alive_cnt_o
    );

    modport slave (
        input  step_i, run_i, frame_tick_i, load_i, rd_addr_i,
        output rd_cell_o, busy_o, gen_o, alive_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/life_nbr_count.sv
`default_nettype none
// ============================================================================
// Module      : life_nbr_count
// Description : Combinational live-neighbour count for one cell, with either
//               toroidal wrap or dead-outside edges.
// Revision    : 1.0 - initial release
// ============================================================================
module life_nbr_count import life_pkg::*; #(
    parameter int COLS_LOG2 = 3,
    parameter int ROWS_LOG2 = 3
) (
    input  wire logic [(2**(COLS_LOG2+ROWS_LOG2))-1:0] cur,
    input  wire logic [COLS_LOG2+ROWS_LOG2-1:0]        idx,
    input  wire logic                                  wrap,
    output logic      [3:0]                            n
);
    localparam int AW   = COLS_LOG2 + ROWS_LOG2;
    localparam int COLS = 2**COLS_LOG2;
    localparam int ROWS = 2**ROWS_LOG2;

    logic [ROWS_LOG2-1:0] w_row;
    logic [COLS_LOG2-1:0] w_col;
    int                   w_r;
    int                   w_c;
    logic                 w_ok;

    assign w_row = idx[AW-1:COLS_LOG2];
    assign w_col = idx[COLS_LOG2-1:0];

    always_comb begin
        n    = 4'd0;
        w_r  = 0;
        w_c  = 0;
        w_ok = 1'b0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!(dr == 0 && dc == 0)) begin
                    w_r  = int'(w_row) + dr;
                    w_c  = int'(w_col) + dc;
                    w_ok = 1'b1;
                    if (wrap) begin
                        w_r = (w_r + ROWS) % ROWS;
                        w_c = (w_c + COLS) % COLS;
                    end else if (w_r < 0 || w_r >= ROWS || w_c < 0 || w_c >= COLS) begin
                        w_ok = 1'b0;
                    end
                    if (w_ok && cur[AW'(w_r * COLS + w_c)] == ALIVE)
                        n = n + 4'd1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/life_engine.sv
`default_nettype none
// ============================================================================
// Module      : life_engine
// Description : Double-buffered Game of Life engine with a tear-free read
//               port. Define LIFE_WRAP_EN for a toroidal board.
// Revision    : 1.0 - initial release
// ============================================================================
module life_engine import life_pkg::*; #(
    parameter int COLS_LOG2 = 3,
    parameter int ROWS_LOG2 = 3,
    parameter logic [(2**(COLS_LOG2+ROWS_LOG2))-1:0] INIT_PATTERN = '0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    life_if.slave     bus
);
    localparam int AW   = COLS_LOG2 + ROWS_LOG2;
    localparam int SIZE = 2**AW;
    localparam int CW   = AW + 1;
    localparam logic [CW-1:0] INIT_POP = CW'(popcount(POP_MAX_BITS'(INIT_PATTERN)));

`ifdef LIFE_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    life_state_t     r_state;
    logic [SIZE-1:0] r_cur;
    logic [SIZE-1:0] r_nxt;
    logic [AW-1:0]   r_idx;
    logic [CW-1:0]   r_acc;
    logic [CW-1:0]   r_alive;
    logic [15:0]     r_gen;
    logic            r_rd_cell;

    logic            w_trigger;
    logic [3:0]      w_n;
    logic            w_new;

    life_nbr_count #(
        .COLS_LOG2 (COLS_LOG2),
        .ROWS_LOG2 (ROWS_LOG2)
    ) u_nbr (
        .cur  (r_cur),
        .idx  (r_idx),
        .wrap (WRAP),
        .n    (w_n)
    );

    assign w_trigger = bus.step_i | (bus.run_i & bus.frame_tick_i);
    assign w_new     = life_rule(r_cur[r_idx], w_n);

    // Reset and load share one path so a mid-generation reload discards work
    always_ff @(posedge clk) begin
        if (!rst_n || bus.load_i) begin
            r_state <= ST_IDLE;
            r_cur   <= INIT_PATTERN;
            r_idx   <= '0;
            r_acc   <= '0;
            r_alive <= INIT_POP;
            r_gen   <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_state <= ST_COMPUTE;
                        r_idx   <= '0;
                        r_acc   <= '0;
                    end
                end
                ST_COMPUTE: begin
                    r_acc <= r_acc + CW'(w_new);
                    r_idx <= r_idx + AW'(1);
                    if (r_idx == AW'(SIZE - 1))
                        r_state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    r_cur   <= r_nxt;
                    r_alive <= r_acc;
                    r_gen   <= r_gen + 16'd1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_nxt <= '0;
        else if (r_state == ST_COMPUTE)
            r_nxt[r_idx] <= w_new;
    end

    // Reads only ever see r_cur, which changes as a whole in COMMIT
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_rd_cell <= 1'b0;
        else
            r_rd_cell <= r_cur[bus.rd_addr_i];
    end

    assign bus.rd_cell_o   = r_rd_cell;
    assign bus.busy_o      = (r_state != ST_IDLE);
    assign bus.gen_o       = r_gen;
    assign bus.alive_cnt_o = r_alive;
endmodule
`default_nettype wire

// File: tb/tb_life_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_life_engine
// Description : Directed bench for life_engine on three 8x8 seeds; edge
//               expectations follow LIFE_WRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_life_engine;

    localparam logic [63:0] SEEDS [3] = '{
        64'h0000_0000_1C00_0000,   // blinker 26,27,28
        64'h0000_0000_0000_0303,   // block 0,1,8,9
        64'h0100_0000_0000_0081    // corners 0,7,56
    };
    localparam int SEED_POP [3] = '{3, 4, 3};

`ifdef LIFE_WRAP_EN
    localparam logic [63:0] CORNER_NEXT  = 64'h8100_0000_0000_0081;
    localparam int          CORNER_ALIVE = 4;
`else
    localparam logic [63:0] CORNER_NEXT  = 64'h0;
    localparam int          CORNER_ALIVE = 0;
`endif

    typedef struct {
        string       name;
        int          sel;
        int          nsteps;
        logic [63:0] board;
        int          alive;
        int          gen;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  step  = '0;
    logic [2:0]  run   = '0;
    logic [2:0]  tick  = '0;
    logic [2:0]  load  = '0;
    logic [5:0]  addr  [3];
    logic [2:0]  rd_w;
    logic [2:0]  busy_w;
    logic [15:0] gen_w   [3];
    logic [6:0]  alive_w [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        life_if #(.COLS_LOG2(3), .ROWS_LOG2(3)) bus ();
        assign bus.step_i       = step[g];
        assign bus.run_i        = run[g];
        assign bus.frame_tick_i = tick[g];
        assign bus.load_i       = load[g];
        assign bus.rd_addr_i    = addr[g];
        assign rd_w[g]          = bus.rd_cell_o;
        assign busy_w[g]        = bus.busy_o;
        assign gen_w[g]         = bus.gen_o;
        assign alive_w[g]       = bus.alive_cnt_o;

        life_engine #(
            .COLS_LOG2    (3),
            .ROWS_LOG2    (3),
            .INIT_PATTERN (SEEDS[g])
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One step pulse, then count the cycles busy stays high
    task automatic do_step(input int sel);
        int cnt;
        @(negedge clk) step[sel] = 1'b1;
        @(negedge clk) step[sel] = 1'b0;
        cnt = 0;
        while (busy_w[sel] && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check("busy_len", 64'(cnt), 64'd65);
    endtask

    task automatic read_board(input int sel, output logic [63:0] b);
        b = '0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk) addr[sel] = 6'(i);
            @(posedge clk);
            #1 b[i] = rd_w[sel];
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [4];
        logic [63:0] board;
        int          cnt;

        vecs[0] = '{"blinker_g1", 0, 1, 64'h0000_0008_0808_0000, 3, 1};
        vecs[1] = '{"blinker_g2", 0, 1, SEEDS[0], 3, 2};
        vecs[2] = '{"block_g3",   1, 3, SEEDS[1], 4, 3};
        vecs[3] = '{"corner_g1",  2, 1, CORNER_NEXT, CORNER_ALIVE, 1};

        for (int g = 0; g < 3; g++) addr[g] = '0;

        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            check("rst_rd_cell", 64'(rd_w[g]), 64'd0);
            check("rst_busy", 64'(busy_w[g]), 64'd0);
            check("rst_gen", 64'(gen_w[g]), 64'd0);
            check("rst_alive", 64'(alive_w[g]), 64'(SEED_POP[g]));
        end
        @(negedge clk) rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            repeat (vecs[v].nsteps) do_step(vecs[v].sel);
            read_board(vecs[v].sel, board);
            check({vecs[v].name, "_board"}, board, vecs[v].board);
            check({vecs[v].name, "_alive"}, 64'(alive_w[vecs[v].sel]), 64'(vecs[v].alive));
            check({vecs[v].name, "_gen"}, 64'(gen_w[vecs[v].sel]), 64'(vecs[v].gen));
        end

        // Run mode: three ticks 100 cycles apart, then ticks with run low
        @(negedge clk) run[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk) tick[0] = 1'b1;
            @(negedge clk) tick[0] = 1'b0;
            repeat (98) @(negedge clk);
        end
        check("run_gen", 64'(gen_w[0]), 64'd5);
        run[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk) tick[0] = 1'b1;
            @(negedge clk) tick[0] = 1'b0;
            check("norun_busy", 64'(busy_w[0]), 64'd0);
            repeat (98) @(negedge clk);
        end
        check("norun_gen", 64'(gen_w[0]), 64'd5);

        // Step while busy and a tick in the COMMIT cycle are both dropped
        @(negedge clk) begin step[2] = 1'b1; run[2] = 1'b1; end
        @(negedge clk) step[2] = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k == 10) step[2] = 1'b1;
            if (k == 11) step[2] = 1'b0;
            if (k == 64) tick[2] = 1'b1;
        end
        check("commit_busy", 64'(busy_w[2]), 64'd1);
        @(negedge clk) tick[2] = 1'b0;
        check("commit_done", 64'(busy_w[2]), 64'd0);
        run[2] = 1'b0;
        repeat (10) @(negedge clk);
        check("drop_busy", 64'(busy_w[2]), 64'd0);
        check("drop_gen", 64'(gen_w[2]), 64'd2);

        // Load at COMPUTE idx 30 discards the generation
        @(negedge clk) step[0] = 1'b1;
        @(negedge clk) step[0] = 1'b0;
        repeat (30) @(negedge clk);
        load[0] = 1'b1;
        @(negedge clk) load[0] = 1'b0;
        check("load_busy", 64'(busy_w[0]), 64'd0);
        check("load_gen", 64'(gen_w[0]), 64'd0);
        check("load_alive", 64'(alive_w[0]), 64'd3);
        read_board(0, board);
        check("load_board", board, SEEDS[0]);

        // Load wins over a simultaneous step
        @(negedge clk) begin load[1] = 1'b1; step[1] = 1'b1; end
        @(negedge clk) begin load[1] = 1'b0; step[1] = 1'b0; end
        cnt = 0;
        for (int k = 0; k < 70; k++) begin
            if (busy_w[1]) cnt++;
            @(negedge clk);
        end
        check("loadstep_busy", 64'(cnt), 64'd0);
        check("loadstep_gen", 64'(gen_w[1]), 64'd0);
        read_board(1, board);
        check("loadstep_board", board, SEEDS[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/life_engine.md
# life_engine

Parameterised Conway's Game of Life engine. It holds a COLS×ROWS double-buffered board, computes one generation per request on the system clock, and serves a registered, tear-free single-cell read port to the VGA pixel pipeline. It sits between the VGA sync generator, which supplies the frame tick, and the RGB colour mux, which consumes the cell value. Board size, seed pattern and edge topology are configurable.

## Interface
Parameters:
- COLS_LOG2, default 3: log2 of board columns; COLS = 2**COLS_LOG2.
- ROWS_LOG2, default 3: log2 of board rows; ROWS = 2**ROWS_LOG2; SIZE = COLS*ROWS.
- INIT_PATTERN, default 64'h0, width SIZE: seed board. Bit index = row*COLS + col.

Ports:
- clk, in, 1: system/pixel clock.
- rst_n, in, 1: reset. One clock; reset is synchronous and active-low.
- step_i, in, 1: single-cycle request for one generation.
- run_i, in, 1: level; when high, each frame_tick_i requests one generation.
- frame_tick_i, in, 1: single-cycle pulse per frame (vsync edge, produced upstream).
- load_i, in, 1: reload INIT_PATTERN.
- rd_addr_i, in, COLS_LOG2+ROWS_LOG2: cell index to read.
- rd_cell_o, out, 1: registered value of display board cell.
- busy_o, out, 1: generation in progress.
- gen_o, out, 16: generation counter.
- alive_cnt_o, out, COLS_LOG2+ROWS_LOG2+1: population of the display board.

## Operation
- Storage: cur[SIZE] is the display board; nxt[SIZE] is the work board.
- FSM states: IDLE, COMPUTE, COMMIT.
- IDLE → COMPUTE when step_i | (run_i & frame_tick_i). idx is set to 0 and the population accumulator is cleared.
- COMPUTE: each cycle, nxt[idx] = rule(cur[idx], n). The accumulator adds the new cell. idx increments; after idx = SIZE-1 the FSM goes to COMMIT.
- COMMIT: cur ← nxt (whole array) and alive_cnt_o ← accumulator. gen_o increments modulo 2^16 (0xFFFF → 0). FSM goes to IDLE.
- Rule B3/S23: a live cell survives with n∈{2,3}; a dead cell is born with n=3; all other cells are dead. n is 4-bit, range 0..8.
- Neighbours: the 8 cells at (row±1, col±1). Edge handling is set by the macro in Configuration.
- Triggers arriving in COMPUTE or COMMIT are dropped; they are not queued.
- load_i in any state: cur ← INIT_PATTERN, gen_o ← 0, alive_cnt_o ← popcount(INIT_PATTERN), FSM → IDLE. Any in-progress generation is discarded.
- load_i takes priority over a simultaneous step_i or frame_tick_i.
- Read port: rd_cell_o ← cur[rd_addr_i] every cycle, in all states.
- Reset values: cur = INIT_PATTERN, nxt = 0, FSM = IDLE, rd_cell_o = 0, busy_o = 0, gen_o = 0, alive_cnt_o = popcount(INIT_PATTERN). Reset mid-COMPUTE behaves identically to load_i.

## Timing
- Trigger sampled at cycle t. busy_o is 1 from t+1 through t+SIZE+1, covering SIZE COMPUTE cycles plus 1 COMMIT cycle.
- The new cur, gen_o and alive_cnt_o are visible at t+SIZE+2, and busy_o falls at the same time. Total latency is SIZE+2 cycles.
- The earliest next trigger is accepted at t+SIZE+2.
- Read latency is 1 cycle. A read issued in the COMMIT cycle returns the old board; the board is never partially updated, so reads are tear-free.

## Configuration
- LIFE_WRAP_EN defined: toroidal board. Row and column indices wrap modulo ROWS and COLS.
- LIFE_WRAP_EN undefined: cells outside the board count as dead.

## Structure
- Package life_pkg holds:
  - the cell state constants ALIVE and DEAD;
  - the FSM state enum;
  - the function life_rule(alive, n);
  - the constant function popcount used for the reset and load value.
- Sub-module life_nbr_count: combinational. Inputs are cur, idx and the wrap mode; output is the 4-bit n. It holds all edge and wrap handling.

## Test plan
- Blinker, 8×8: seed cells 26,27,28; pulse step_i → busy_o high for 65 cycles. Then the live cells are exactly 19,27,35, gen_o = 1 and alive_cnt_o = 3. Step again → cells 26,27,28, gen_o = 2.
- Block still life: seed 0,1,8,9, with the macro both on and off; run 3 generations → the board is unchanged and alive_cnt_o = 4.
- Corner seed 0,7,56:
  - with LIFE_WRAP_EN → cells 0,7,56,63, alive_cnt_o = 4;
  - without it → empty board, alive_cnt_o = 0.
- Run mode: run_i = 1 with frame_tick_i every 100 cycles → gen_o increments once per tick. With run_i = 0, ticks have no effect.
- step_i pulsed while busy_o = 1 → ignored, gen_o advances by exactly 1. A tick coinciding with the COMMIT cycle is also dropped.
- load_i at COMPUTE idx = 30 → the next cycle shows busy_o = 0, gen_o = 0 and the board = INIT_PATTERN. load_i together with step_i in IDLE → load only, and no generation runs.
